bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Iterative (shift-add-3 / double-dabble) binary-to-BCD converter feeding the display digit mux.
//  Converts a BIN_W-bit unsigned value into 3 packed BCD digits cdu = {centenas,decenas,unidades}.
//  Sits directly upstream of the digit mux; its cdu output is held stable between conversions
//  so the scanned display never flickers.
// PARAMETERS
//  BIN_W   10   width of binary input; legal range 4..10 (max input 1023)
// PORTS
//  clk     in   1      system clock, all state on rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request conversion of bin; sampled only in IDLE
//  bin     in   BIN_W  unsigned binary value, captured on the accepting edge
//  busy    out  1      high while a conversion is in progress (CONVERT or LOAD)
//  done    out  1      registered one-cycle pulse: new cdu/ovf valid
//  cdu     out  12     BCD result: [3:0] unidades, [7:4] decenas, [11:8] centenas
//  ovf     out  1      last converted value exceeded 999; cdu saturated
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, cdu=12'h000, ovf=0; scratch regs cleared.
//  FSM states: IDLE -> CONVERT -> LOAD -> IDLE.
//   IDLE: start=1 at edge T0 -> capture bin into shift reg, clear 16-bit BCD scratch,
//         iter count = BIN_W, ovf_pend = (bin > 999), go CONVERT, busy=1.
//   CONVERT: each edge: every scratch digit >= 5 gets +3, then {scratch,shift} <<= 1;
//         count decrements; after BIN_W shift edges (T1..T_BIN_W) go LOAD.
//   LOAD: at edge T_{BIN_W+1}: cdu <= ovf_pend ? 12'h999 : scratch[11:0]; ovf <= ovf_pend;
//         done <= 1; busy <= 0; go IDLE.
//  Latency: done high in cycle after edge T_{BIN_W+1}; BIN_W+1 cycles after start accepted
//  (11 for default). Throughput: one conversion per BIN_W+2 cycles.
//  done is high exactly one cycle; start asserted in that cycle is accepted (back-to-back ok).
//  start while busy=1: ignored, no queuing; bin changes while busy have no effect.
//  cdu/ovf change only at the LOAD edge; otherwise hold previous result.
//  Scratch is 4 digits (16 b) so 1000..1023 convert without wrap; only ovf path saturates.
//  Every cdu nibble is always a legal BCD digit (0..9).
//  Async reset mid-conversion: abort, outputs to reset values, no done pulse.
//  start held high continuously: new conversion each BIN_W+2 cycles.
// STRUCTURE
//  Shared package bcd_pkg: typedef logic [3:0] bcd_digit_t; typedef logic [11:0] bcd3_t;
//   localparam bcd3_t BCD_MAX = 12'h999; localparam int BCD_MAX_BIN = 999;
//   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_LOAD} b2b_state_t.
//  One sub-module: bcd_add3 (combinational: in>=5 ? in+3 : in), instantiated per scratch digit.
//  Counter width $clog2(BIN_W+1).
// TESTING
//  1. bin=0, start pulse -> done after 11 cycles, cdu=12'h000, ovf=0; busy high 11 cycles.
//  2. bin=255 -> cdu=12'h255; bin=9 -> 12'h009; bin=999 -> 12'h999, ovf=0.
//  3. bin=1000 and bin=1023 -> cdu=12'h999, ovf=1; next bin=42 -> cdu=12'h042, ovf=0.
//  4. start bin=123, re-pulse start with bin=456 at cycle 5 -> ignored; result 12'h123 only.
//  5. rst_n low at cycle 6 of bin=777 conversion -> cdu=0, busy=0, no done; restart bin=777 -> 12'h777.
//  6. start held high, bin=321 then 654 -> done every 12 cycles, cdu 12'h321 then 12'h654; cdu stable between.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the binary-to-BCD converter and the display path.
package bcd_pkg;

   typedef logic [3:0]  bcd_digit_t;
   typedef logic [11:0] bcd3_t;

   localparam bcd3_t BCD_MAX     = 12'h999;
   localparam int    BCD_MAX_BIN = 999;

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_LOAD} b2b_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);

   bcd_digit_t sum;

   always_comb begin
      sum = d_i + 4'd3;
      d_o = (d_i >= 4'd5) ? sum : d_i;
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter; result held stable between conversions.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [11:0]      cdu,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   b2b_state_t          state_q, state_d;
   logic [BIN_W-1:0]    shift_q, shift_d;
   logic [15:0]         scratch_q, scratch_d;
   logic [15:0]         adj;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_pend_q, ovf_pend_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;
   bcd3_t               cdu_q, cdu_d;
   logic [16+BIN_W-1:0] shifted;

   // Four scratch digits so 1000..1023 never wrap during the shift.
   for (genvar i = 0; i < 4; i++) begin : g_add3
      bcd_add3 u_add3 (
         .d_i (scratch_q[4*i +: 4]),
         .d_o (adj[4*i +: 4])
      );
   end

   assign shifted = {adj, shift_q} << 1;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      done_d     = 1'b0;
      cdu_d      = cdu_q;
      ovf_d      = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d    = bin;
               scratch_d  = '0;
               cnt_d      = CNT_W'(BIN_W);
               ovf_pend_d = (int'(bin) > BCD_MAX_BIN);
               state_d    = S_CONVERT;
            end
         end
         S_CONVERT: begin
            scratch_d = shifted[BIN_W +: 16];
            shift_d   = shifted[BIN_W-1:0];
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_LOAD;
         end
         S_LOAD: begin
            cdu_d   = ovf_pend_q ? BCD_MAX : scratch_q[11:0];
            ovf_d   = ovf_pend_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         done_q     <= 1'b0;
         cdu_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         done_q     <= done_d;
         cdu_q      <= cdu_d;
         ovf_q      <= ovf_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign cdu  = cdu_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: per-cycle comparison against a timing/arithmetic model plus pinned cases.
module tb_bin_to_bcd_seq;

   localparam int BIN_W = 10;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [BIN_W-1:0] bin   = '0;
   logic             busy, done, ovf;
   logic [11:0]      cdu;

   int n_cmp = 0;
   int n_err = 0;

   bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .cdu   (cdu),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int v);
      if (v > 999) return 12'h999;
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Model: a conversion accepted in idle yields its result BIN_W+1 edges later.
   logic        m_busy, m_done, m_ovf;
   logic [11:0] m_cdu;
   int          m_timer, m_val;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_ovf   <= 1'b0;
         m_cdu   <= 12'h000;
         m_timer <= 0;
         m_val   <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy  <= 1'b1;
               m_timer <= BIN_W + 1;
               m_val   <= int'(bin);
            end
         end else if (m_timer == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_cdu  <= to_bcd(m_val);
            m_ovf  <= (m_val > 999);
         end else begin
            m_timer <= m_timer - 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic conv(input int v, output int lat, output int bcyc);
      @(negedge clk);
      start = 1'b1;
      bin   = BIN_W'(v);
      lat   = 0;
      bcyc  = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (busy) bcyc++;
      end while (!done && lat < 40);
      chk("done_seen", int'(done), 1);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < 40);
      chk("done_seen", int'(done), 1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int lat, bcyc, cyc;
      bit chk_en;
      chk_en = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (chk_en) begin
               chk("busy", int'(busy), int'(m_busy));
               chk("done", int'(done), int'(m_done));
               chk("cdu", int'(cdu), int'(m_cdu));
               chk("ovf", int'(ovf), int'(m_ovf));
               chk("bcd_legal", int'(cdu[3:0] <= 4'd9 && cdu[7:4] <= 4'd9 && cdu[11:8] <= 4'd9), 1);
            end
         end
      join_none

      #1 rst_n = 1'b0;
      idle_cycles(2);
      chk_en = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cdu", int'(cdu), 12'h000);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ovf", int'(ovf), 0);

      // Zero input, latency and busy duration
      conv(0, lat, bcyc);
      chk("lat_0", lat - 1, 11);
      chk("busy_cycles_0", bcyc, 11);
      chk("cdu_0", int'(cdu), 12'h000);
      chk("ovf_0", int'(ovf), 0);

      conv(255, lat, bcyc);
      chk("cdu_255", int'(cdu), 12'h255);
      conv(9, lat, bcyc);
      chk("cdu_9", int'(cdu), 12'h009);
      conv(999, lat, bcyc);
      chk("cdu_999", int'(cdu), 12'h999);
      chk("ovf_999", int'(ovf), 0);

      // Saturation above 999, then recovery
      conv(1000, lat, bcyc);
      chk("cdu_1000", int'(cdu), 12'h999);
      chk("ovf_1000", int'(ovf), 1);
      conv(1023, lat, bcyc);
      chk("cdu_1023", int'(cdu), 12'h999);
      chk("ovf_1023", int'(ovf), 1);
      conv(42, lat, bcyc);
      chk("cdu_42", int'(cdu), 12'h042);
      chk("ovf_42", int'(ovf), 0);

      // Start while busy is ignored
      @(negedge clk);
      start = 1'b1;
      bin   = 10'd123;
      @(negedge clk);
      start = 1'b0;
      idle_cycles(3);
      start = 1'b1;
      bin   = 10'd456;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      chk("cdu_123", int'(cdu), 12'h123);
      idle_cycles(15);
      chk("cdu_123_held", int'(cdu), 12'h123);

      // Reset mid-conversion aborts with no done
      @(negedge clk);
      start = 1'b1;
      bin   = 10'd777;
      @(negedge clk);
      start = 1'b0;
      idle_cycles(4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_cdu", int'(cdu), 12'h000);
      chk("abort_busy", int'(busy), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      cyc = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) cyc++;
      end
      chk("abort_no_done", cyc, 0);
      conv(777, lat, bcyc);
      chk("cdu_777", int'(cdu), 12'h777);

      // Start held high: back-to-back conversions
      @(negedge clk);
      start = 1'b1;
      bin   = 10'd321;
      wait_done(cyc);
      chk("held_first_interval", cyc, 12);
      chk("cdu_321", int'(cdu), 12'h321);
      bin = 10'd654;
      wait_done(cyc);
      chk("held_interval", cyc, 12);
      chk("cdu_654", int'(cdu), 12'h654);
      start = 1'b0;
      idle_cycles(14);

      // Random start pulses and input churn
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 5))
            0:       bin = BIN_W'($urandom_range(995, 1023));
            1:       bin = BIN_W'($urandom_range(0, 12));
            default: bin = BIN_W'($urandom_range(0, 1023));
         endcase
      end
      start = 1'b0;
      idle_cycles(15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
